// File: rtl/sram_ctrl_pkg.sv
// Shared types and bus constants for the SRAM controller slice.
package sram_ctrl_pkg;

  localparam int   REG_BUS      = 32;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam int   TIMER_W      = 4;

  typedef enum logic [2:0] {
    SramIdle    = 3'd0,
    SramSetup   = 3'd1,
    SramPulse   = 3'd2,
    SramDone    = 3'd3,
    SramRelease = 3'd4
  } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// MEM-stage data-memory bus: request from the pipeline, ready/data back from memory.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic               ce;
  logic               we;
  logic [3:0]         sel;
  logic [REG_BUS-1:0] addr;
  logic [REG_BUS-1:0] wdata;
  logic [REG_BUS-1:0] rdata;
  logic               ready;
  logic               err;

  modport master (output ce, we, sel, addr, wdata, input rdata, ready, err);
  modport slave  (input ce, we, sel, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/sram_wait_timer.sv
// Loadable down-counter that times the strobe-active phase of an SRAM access.
module sram_wait_timer
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage bus to asynchronous 32-bit SRAM: SETUP, timed PULSE, DONE (ready), RELEASE.
// Define SRAM_CTRL_ERR_EN to fast-fail sel==0 requests with a ready+err pulse.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [REG_BUS-1:0] sram_dq_wr,
  input  logic [REG_BUS-1:0] sram_dq_rd,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(WAIT_CYCLES - 1);

  state_t             state;
  logic               req_we;
  logic               ready_q;
  logic [REG_BUS-1:0] rdata_q;
  logic               bad_sel;
  logic               timer_zero;

  // Only the word-address field reaches the pads.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[REG_BUS-1:ADDR_W+2], bus.addr[1:0]};

`ifdef SRAM_CTRL_ERR_EN
  logic err_q;
  assign bad_sel = (bus.sel == 4'b0000);
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == SramIdle) && (bus.ce == CHIP_ENABLE) && bad_sel;
  end
  assign bus.err = err_q;
`else
  assign bad_sel = 1'b0;
  assign bus.err = 1'b0;
`endif

  sram_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == SramSetup),
    .dec      (state == SramPulse),
    .load_val (WAIT_LOAD),
    .zero     (timer_zero)
  );

  // Pad outputs are set on the edge entering each state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SramIdle;
      req_we     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      sram_addr  <= '0;
      sram_dq_wr <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      ready_q <= 1'b0;
      case (state)
        SramIdle: begin
          if (bus.ce == CHIP_ENABLE) begin
            if (bad_sel) begin
              state   <= SramDone;
              ready_q <= 1'b1;
            end else begin
              state     <= SramSetup;
              req_we    <= bus.we;
              sram_addr <= bus.addr[ADDR_W+1:2];
              sram_be_n <= ~bus.sel;
              sram_ce_n <= 1'b0;
              if (bus.we == WRITE_ENABLE) begin
                sram_dq_oe <= 1'b1;
                sram_dq_wr <= bus.wdata;
              end else begin
                sram_oe_n <= 1'b0;
              end
            end
          end
        end
        SramSetup: begin
          state <= SramPulse;
          if (req_we) sram_we_n <= 1'b0;
        end
        SramPulse: begin
          if (timer_zero) begin
            state     <= SramDone;
            ready_q   <= 1'b1;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!req_we) rdata_q <= sram_dq_rd;
          end
        end
        SramDone: begin
          // Address/data were held through the write-hold cycle; now release the bus.
          state      <= SramRelease;
          sram_ce_n  <= 1'b1;
          sram_be_n  <= 4'hF;
          sram_dq_oe <= 1'b0;
        end
        SramRelease: begin
          if (bus.ce != CHIP_ENABLE) state <= SramIdle;
        end
        default: state <= SramIdle;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench: three controllers (W=2,1,15) driven in lockstep against a word-level memory model.
module tb_sram_ctrl;

  localparam int NI = 3;
  localparam logic [NI-1:0][3:0] WS = {4'd15, 4'd1, 4'd2};
`ifdef SRAM_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be_n;
    logic [19:0] word;
    int          n_ce, n_oe, n_we, n_dq;
  } exp_t;

  exp_t expq [NI][$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  logic        ce_d = 1'b0, we_d = 1'b0;
  logic [3:0]  sel_d = 4'h0;
  logic [31:0] addr_d = '0, data_d = '0;
  int          raise_cyc = 0;
  int          errors = 0, checks = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] last_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int W = int'(WS[g]);
    sram_ctrl_if bus ();
    logic [19:0] s_addr;
    logic [31:0] s_dq_wr, s_dq_rd;
    logic        s_dq_oe, s_ce_n, s_oe_n, s_we_n;
    logic [3:0]  s_be_n;
    logic [31:0] smem [16];

    assign bus.ce    = ce_d;
    assign bus.we    = we_d;
    assign bus.sel   = sel_d;
    assign bus.addr  = addr_d;
    assign bus.wdata = data_d;

    sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sram_addr(s_addr), .sram_dq_wr(s_dq_wr), .sram_dq_rd(s_dq_rd),
      .sram_dq_oe(s_dq_oe), .sram_ce_n(s_ce_n), .sram_oe_n(s_oe_n),
      .sram_we_n(s_we_n), .sram_be_n(s_be_n)
    );

    // Pin-level SRAM: drives data only while selected and output-enabled.
    assign s_dq_rd = (!s_ce_n && !s_oe_n) ? smem[s_addr[3:0]] : 32'hBAD0BAD0;
    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 16; i++) smem[i] <= '0;
      end else if (!s_ce_n && !s_we_n && s_dq_oe) begin
        for (int l = 0; l < 4; l++)
          if (!s_be_n[l]) smem[s_addr[3:0]][8*l +: 8] <= s_dq_wr[8*l +: 8];
      end
    end

    initial begin : mon
      exp_t e;
      int n_ce, n_oe, n_we, n_dq;
      bit post;
      logic [31:0] post_rd;
      n_ce = 0; n_oe = 0; n_we = 0; n_dq = 0; post = 0; post_rd = '0;
      forever begin
        @(negedge clk);
        if (rst_seen) begin
          chk($sformatf("w%0d_rst_ce_n", W), 32'(s_ce_n), 32'd1);
          chk($sformatf("w%0d_rst_oe_n", W), 32'(s_oe_n), 32'd1);
          chk($sformatf("w%0d_rst_we_n", W), 32'(s_we_n), 32'd1);
          chk($sformatf("w%0d_rst_be_n", W), 32'(s_be_n), 32'hF);
          chk($sformatf("w%0d_rst_dq_oe", W), 32'(s_dq_oe), 32'd0);
          chk($sformatf("w%0d_rst_addr", W), 32'(s_addr), 32'd0);
          chk($sformatf("w%0d_rst_dq", W), s_dq_wr, 32'd0);
          chk($sformatf("w%0d_rst_ready", W), 32'(bus.ready), 32'd0);
          chk($sformatf("w%0d_rst_err", W), 32'(bus.err), 32'd0);
          chk($sformatf("w%0d_rst_rdata", W), bus.rdata, 32'd0);
          n_ce = 0; n_oe = 0; n_we = 0; n_dq = 0; post = 0;
        end else begin
          if (post) begin
            chk($sformatf("w%0d_rdata_hold", W), bus.rdata, post_rd);
            post = 0;
          end
          if (!s_ce_n) n_ce++;
          if (!s_oe_n) n_oe++;
          if (!s_we_n) n_we++;
          if (s_dq_oe) n_dq++;
          if (bus.ready) begin
            if (expq[g].size() == 0) begin
              checks++; errors++;
              $display("FAIL w%0d_unexpected_ready: got ready at cycle %0d expected none", W, cyc);
            end else begin
              e = expq[g].pop_front();
              chk($sformatf("w%0d_latency", W), 32'(cyc - raise_cyc), 32'(e.lat));
              chk($sformatf("w%0d_err", W), 32'(bus.err), 32'(e.err));
              chk($sformatf("w%0d_rdata", W), bus.rdata, e.rdata);
              chk($sformatf("w%0d_ce_low_cycles", W), 32'(n_ce), 32'(e.n_ce));
              chk($sformatf("w%0d_oe_low_cycles", W), 32'(n_oe), 32'(e.n_oe));
              chk($sformatf("w%0d_we_low_cycles", W), 32'(n_we), 32'(e.n_we));
              chk($sformatf("w%0d_dq_oe_cycles", W), 32'(n_dq), 32'(e.n_dq));
              if (e.n_ce != 0) begin
                chk($sformatf("w%0d_be_n", W), 32'(s_be_n), 32'(e.be_n));
                chk($sformatf("w%0d_sram_addr", W), 32'(s_addr), 32'(e.word));
              end
              post = 1; post_rd = e.rdata;
            end
            n_ce = 0; n_oe = 0; n_we = 0; n_dq = 0;
          end
        end
      end
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < NI; i++) if (expq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Issue one request at a negedge; expectations come from the word-level model.
  task automatic do_req(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] data, input int hold, input bit abort);
    bit bad;
    int idx;
    logic [31:0] exp_rd;
    exp_t e;
    bad = ERR_EN && (sel == 4'b0000);
    idx = int'(addr[5:2]);
    if (we) begin
      if (!bad && !abort)
        for (int l = 0; l < 4; l++) if (sel[l]) ref_mem[idx][8*l +: 8] = data[8*l +: 8];
      exp_rd = last_rdata;
    end else begin
      exp_rd = bad ? last_rdata : ref_mem[idx];
    end
    last_rdata = exp_rd;
    for (int i = 0; i < NI; i++) begin
      e.lat   = bad ? 1 : int'(WS[i]) + 2;
      e.err   = bad;
      e.rdata = exp_rd;
      e.be_n  = ~sel;
      e.word  = addr[21:2];
      e.n_ce  = bad ? 0 : int'(WS[i]) + 2;
      e.n_oe  = (bad || we) ? 0 : int'(WS[i]) + 1;
      e.n_we  = (bad || !we) ? 0 : int'(WS[i]);
      e.n_dq  = (bad || !we) ? 0 : int'(WS[i]) + 2;
      expq[i].push_back(e);
    end
    ce_d = 1'b1; we_d = we; sel_d = sel; addr_d = addr; data_d = data;
    raise_cyc = cyc;
    if (abort) begin
      repeat (3) @(negedge clk);
      rst = 1'b1; ce_d = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) expq[i].delete();
      last_rdata = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      return;
    end
    for (int k = 0; k < 40 && !all_empty(); k++) @(posedge clk);
    if (!all_empty()) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready within 40 cycles expected ready");
      for (int i = 0; i < NI; i++) expq[i].delete();
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    ce_d = 1'b0;
    // Inputs change after acceptance must be ignored.
    sel_d = 4'($urandom); addr_d = $urandom; data_d = $urandom;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b1, 4'hF, 32'h0000_0040, 32'hDEADBEEF, 0, 1'b0);
    do_req(1'b0, 4'hF, 32'h0000_0040, 32'h0, 3, 1'b0);
    do_req(1'b1, 4'b0100, 32'h0000_0102, 32'hA5A5A5A5, 1, 1'b0);
    do_req(1'b0, 4'b0100, 32'h0000_0040, 32'h0, 0, 1'b0);
    do_req(1'b1, 4'b0000, 32'h0000_0044, 32'h12345678, 0, 1'b0);
    do_req(1'b0, 4'b0000, 32'h0000_0044, 32'h0, 2, 1'b0);
    do_req(1'b1, 4'hF, 32'h0000_0048, 32'hCAFEF00D, 0, 1'b1);
    do_req(1'b1, 4'hF, 32'h0000_0048, 32'h0BADF00D, 0, 1'b0);
    do_req(1'b0, 4'hF, 32'h0000_0048, 32'h0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      do_req(r[0], r[7:4], $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-side responder for the CPU data-memory bus driven by the MEM stage. Accepts the `mem_ce`/`mem_we`/`mem_sel`/`mem_addr`/`mem_data` request, converts it into a multi-cycle asynchronous SRAM access, and returns read data plus a one-cycle `ready` pulse. The MEM stage's stall/`cnt` handshake depends on this pulse. The block sits between the MEM stage and the board's 32-bit external SRAM.

## Interface
- `ADDR_W`, default 20: SRAM word-address width. Byte address bits `[ADDR_W+1:2]` are used; higher bits are ignored.
- `WAIT_CYCLES`, default 2: number of strobe-active cycles per access. Legal range 1..15.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `mem_ce_i`, in, 1: request valid (`ChipEnable`). Held by the initiator until `ready` is seen.
- `mem_we_i`, in, 1: 1 = write, 0 = read.
- `mem_sel_i`, in, 4: byte enables, bit n = byte lane n.
- `mem_addr_i`, in, 32: byte address.
- `mem_data_i`, in, 32: write data, lane-replicated by the initiator.
- `mem_data_o`, out, 32: read data, held until the next accepted read.
- `mem_ready_o`, out, 1: access complete, one-cycle pulse.
- `mem_err_o`, out, 1: illegal request. Only present with `SRAM_CTRL_ERR_EN`; otherwise tied to 0.
- `sram_addr_o`, out, `ADDR_W`: SRAM word address.
- `sram_dq_o`, out, 32: SRAM write data.
- `sram_dq_i`, in, 32: SRAM read data.
- `sram_dq_oe_o`, out, 1: pad output enable for `sram_dq`.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o`, out, 1 each: SRAM strobes, active-low.
- `sram_be_n_o`, out, 4: SRAM byte enables, active-low.

## Operation
- The FSM has five states: IDLE, SETUP, PULSE, DONE, RELEASE.
- IDLE, `mem_ce_i`=1: latch `addr`, `we`, `sel` and `data` into request registers, then go to SETUP. Input changes after this edge are ignored.
- SETUP, one cycle:
  - `sram_ce_n`=0 and `sram_addr` valid.
  - `sram_be_n` = ~`sel`.
  - Write: `sram_dq_oe`=1 and `sram_dq_o` = latched data, `sram_we_n`=1.
  - Read: `sram_oe_n`=0.
  - Reload the wait counter with `WAIT_CYCLES`-1.
- PULSE, `WAIT_CYCLES` cycles:
  - Write: `sram_we_n`=0.
  - Read: `sram_oe_n`=0.
  - The counter decrements each cycle; at 0, go to DONE.
  - Read: capture `sram_dq_i` into the `mem_data_o` register on the final PULSE edge. Lanes not selected still capture; the initiator extracts lanes.
- DONE, one cycle:
  - `mem_ready_o`=1 and `sram_we_n`=1 (write hold).
  - Address, data and `dq_oe` are held.
  - Go to RELEASE.
- RELEASE: all strobes inactive. Go to IDLE at the first edge with `mem_ce_i`=0. This prevents re-triggering while the initiator still holds `ce` in the `ready` cycle.
- `mem_data_o` is unchanged by writes and by RELEASE/IDLE. The initiator samples it one cycle after `ready`.
- `rst` wins over everything, including mid-access. The next state is IDLE, and all strobes go inactive at the next edge.

## Timing
- Reset values:
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
  - `sram_be_n` = 4'hF.
  - `sram_dq_oe` = 0; `sram_addr` and `sram_dq_o` = 0.
  - `mem_ready_o` = 0, `mem_err_o` = 0, `mem_data_o` = 0, state = IDLE.
- All outputs are registered or Moore-decoded from state; there are no combinational paths from the `mem_*` inputs.
- Latency: request sampled at edge T. SETUP is cycle T+1, PULSE is cycles T+2..T+1+W, and `ready` is high in cycle T+2+W. With W=2, `ready` comes 4 cycles after acceptance.
- Minimum request spacing: `ready` cycle, then at least one cycle of `ce`=0, then the next request.
- Write data/address are stable one cycle before `we_n` falls and one cycle after it rises.

## Configuration
- Macro: `SRAM_CTRL_ERR_EN`.
- Defined:
  - A request with `mem_sel_i`=4'b0000 (misaligned SH/SB from the MEM stage) skips SETUP/PULSE.
  - It goes IDLE→DONE, so `ready` and `mem_err_o` pulse together in cycle T+1.
  - The SRAM is not touched and `mem_data_o` is unchanged.
- Undefined: `mem_err_o` is constant 0. A sel=0 request runs the full access with `be_n`=4'hF, writing nothing and reading normally.

## Structure
- `defines.v` holds:
  - FSM state encodings `SramIdle`, `SramSetup`, `SramPulse`, `SramDone`, `SramRelease` (3 bits).
  - The existing `RegBus`, `ChipEnable` and `WriteEnable`.
- One sub-module: `sram_wait_timer`, a loadable 4-bit down-counter with a `zero` flag used by PULSE.

## Test plan
- Read, W=2: SRAM returns 32'hDEADBEEF at word 0x00010 (`mem_addr_i`=32'h40). Expect `oe_n` low for 3 cycles, `ready` at T+4, and `mem_data_o`=32'hDEADBEEF held after `ce` drops.
- SB: `sel`=4'b0100, data 32'hA5A5A5A5, addr 32'h102. Expect `be_n`=4'b1011, `we_n` low exactly 2 cycles, and `dq_oe` high SETUP through DONE.
- `ce` held high for 3 cycles after `ready`: no second access; FSM stays in RELEASE until `ce`=0.
- `rst` asserted in the 2nd PULSE cycle of a write: next edge `we_n`=1, `ce_n`=1, `dq_oe`=0, no `ready`; a new request then completes normally.
- `SRAM_CTRL_ERR_EN`, `sel`=4'b0000 write: `ready`=`err`=1 at T+1 and `sram_ce_n` stays 1. Without the macro: `ready` at T+4, `err`=0, `be_n`=4'hF.
- `WAIT_CYCLES`=1 and 15: `ready` at T+3 and T+17 respectively.
